sha256_spi_slave: RTL and testbench
===================================

Name: sha256_spi_slave

Overview:
SPI slave front-end for the SHA-256 accelerator. It oversamples the external SPI pins in the i_clk domain and assembles 16-bit frames of the form {n_r_w, addr[6:0], data[7:0]}. It issues single-cycle write or read requests to the downstream register bank. Read data is returned in the low byte of the next frame on MISO. SPI mode 3: SCK idles high, master drives on falling edges, slave samples on rising edges.

Parameters:
FRAME_W, 16, total SPI frame length in bits
ADDR_W, 7, register address width
DATA_W, 8, register data width

Ports:
i_clk  in  1  system clock; must be at least 4x SCK frequency
i_rst_n  in  1  asynchronous active-low reset
i_sck  in  1  SPI clock, asynchronous, idle high
i_ss_n  in  1  SPI slave select, active low, asynchronous
i_spi_mosi  in  1  SPI data in, MSB first
o_spi_miso  out  1  SPI data out, MSB first
o_wr_en  out  1  one-cycle write strobe to register bank
o_rd_en  out  1  one-cycle read strobe to register bank
o_addr  out  ADDR_W  register address, valid with o_wr_en/o_rd_en
o_wdata  out  DATA_W  write data, valid with o_wr_en
i_rdata  in  DATA_W  register bank read data, valid 1 cycle after o_rd_en
o_frame_err  out  1  one-cycle pulse: frame was not exactly FRAME_W bits
o_busy  out  1  high while ss_n is (synchronised) low

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active low.
- Reset values: all outputs 0; shift registers 0; bit counter 0; rd_buf 0; state IDLE.
- Synchronisation: i_sck, i_ss_n and i_spi_mosi each pass through a 2-FF synchroniser. Reset values: sck 1, ss_n 1, mosi 0.
- Edge detection: registered previous value of synced sck gives sck_rise and sck_fall. Same for ss_n, giving ss_fall and ss_rise.
- States:
  - IDLE -> SHIFT on ss_fall.
  - SHIFT -> COMMIT on ss_rise.
  - COMMIT -> IDLE after 1 cycle (2 cycles for a read; see below).
- IDLE:
  - o_spi_miso = 0.
  - On ss_fall: clear bit_cnt and rx_shift; load tx_shift = {8'h00, rd_buf}.
- SHIFT:
  - sck_rise: rx_shift <= {rx_shift[14:0], mosi}. bit_cnt increments and saturates at FRAME_W+1.
  - sck_fall: o_spi_miso <= tx_shift[15]; tx_shift <= tx_shift << 1.
  - If both edges are flagged in one cycle (glitch), the rise takes priority.
- COMMIT, entered on ss_rise:
  - bit_cnt == 16 and rx[15] == 1: o_wr_en=1, o_addr=rx[14:8], o_wdata=rx[7:0], all for exactly 1 cycle.
  - bit_cnt == 16 and rx[15] == 0: o_rd_en=1 and o_addr=rx[14:8] for 1 cycle. The next cycle captures rd_buf <= i_rdata.
  - bit_cnt != 16 (short or long frame): no strobe, o_frame_err=1 for 1 cycle, rd_buf unchanged.
- Latency: strobe is asserted 4 i_clk cycles (+/-1) after the i_ss_n rising edge (2 sync + 1 edge detect + 1 register).
- rd_buf holds its value until the next valid read. Every frame shifts out rd_buf, write or read. A read of address A therefore needs a second frame to return its data.
- ss_n deasserted mid-frame: treated as a short frame, giving an error pulse. The counter and shift registers are cleared on the next ss_fall.
- ss_fall arriving during COMMIT: COMMIT completes first. Then the state machine enters SHIFT in the same cycle the fall is seen. The fall event is held in a 1-bit pending flag.
- Async reset mid-frame: immediate return to reset values. The remainder of the frame is ignored until the next ss_fall.
- o_busy = ~ss_n_sync.

Decomposition:
- Package sha256_spi_pkg holds: FRAME_W, ADDR_W, DATA_W, RW_BIT=15, CMD_WRITE=1'b1, CMD_READ=1'b0, state encoding localparams (IDLE, SHIFT, COMMIT).
- One sub-module: sha256_sync2, a generic 2-FF synchroniser with parameterised reset value, instantiated three times.

Test Plan:
1. Write frame 16'h85A5 (wr, addr 5, data A5), i_clk 20 MHz, SCK 2 MHz -> exactly one o_wr_en pulse with o_addr=5, o_wdata=8'hA5; o_frame_err stays 0.
2. Read frame 16'h4600 (addr 70) with bank returning i_rdata=8'hBA, then a second frame -> one o_rd_en pulse with o_addr=70. Bits sampled on the second frame's SCK rising edges equal 16'h00BA.
3. 64 back-to-back writes, addr k with data k^8'h3C, 1 us gap between frames -> 64 strobes, in order, no missed or duplicated strobe.
4. Frame truncated after 9 SCK cycles (ss_n raised early) -> o_frame_err one pulse, no wr/rd strobe. A following valid 16'h8101 frame produces a normal write.
5. 17-bit frame -> o_frame_err pulse, no strobe, rd_buf unchanged (next frame still returns the previous read value).
6. i_rst_n asserted after bit 8 of a write frame -> all outputs 0 immediately. After release, no strobe for that frame; the next full frame works.

Source files
------------

// File: rtl/sha256_spi_pkg.sv
// Shared constants for the SHA-256 accelerator SPI slave front-end.
// Frame layout: {n_r_w, addr[6:0], data[7:0]}, MSB first.
package sha256_spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int RW_BIT  = 15;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

endpackage

// File: rtl/sha256_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable
// reset level so idle-high lines do not produce a false edge out of reset.
module sha256_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sha256_spi_slave.sv
// SPI mode-3 slave that oversamples SCK/SS/MOSI in i_clk and turns each
// 16-bit frame into a single-cycle register-bank write or read request.
//
// state  | meaning
// IDLE   | ss_n high, waiting for a falling edge
// SHIFT  | frame in progress, shifting on synced SCK edges
// COMMIT | frame closed; strobe/error cycle, plus a capture cycle for reads
module sha256_spi_slave
    import sha256_spi_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sck,
    input  logic              i_ss_n,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_wr_en,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_frame_err,
    output logic              o_busy
);

    logic sck_s, ss_n_s, mosi_s;
    logic sck_prev, ss_prev;
    logic sck_rise, sck_fall, ss_fall, ss_rise;

    logic [1:0]         state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] rx_shift, tx_shift;
    logic [DATA_W-1:0]  rd_buf;
    logic               rd_capture, ss_pend;
    logic               frame_ok, is_read, commit_done, start;

    sha256_sync2 #(.RST_VAL(1'b1)) u_sync_sck  (.clk(i_clk), .rst_n(i_rst_n), .d(i_sck),      .q(sck_s));
    sha256_sync2 #(.RST_VAL(1'b1)) u_sync_ss   (.clk(i_clk), .rst_n(i_rst_n), .d(i_ss_n),     .q(ss_n_s));
    sha256_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(i_clk), .rst_n(i_rst_n), .d(i_spi_mosi), .q(mosi_s));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_prev <= 1'b1;
            ss_prev  <= 1'b1;
        end else begin
            sck_prev <= sck_s;
            ss_prev  <= ss_n_s;
        end
    end

    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign ss_fall  = ~ss_n_s & ss_prev;
    assign ss_rise  = ss_n_s & ~ss_prev;

    assign frame_ok    = (bit_cnt == CNT_W'(FRAME_W));
    assign is_read     = frame_ok && (rx_shift[RW_BIT] == CMD_READ);
    assign commit_done = (state == COMMIT) && (!is_read || rd_capture);
    // A fall seen (or remembered) while committing starts the next frame directly.
    assign start       = ((state == IDLE) && ss_fall) || (commit_done && (ss_fall || ss_pend));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = SHIFT;
            SHIFT:   if (ss_rise) state_nxt = COMMIT;
            COMMIT:  if (commit_done) state_nxt = (ss_fall || ss_pend) ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_wr_en     = 1'b0;
        o_rd_en     = 1'b0;
        o_frame_err = 1'b0;
        o_addr      = '0;
        o_wdata     = '0;
        if (state == COMMIT && !rd_capture) begin
            o_frame_err = ~frame_ok;
            o_wr_en     = frame_ok && (rx_shift[RW_BIT] == CMD_WRITE);
            o_rd_en     = is_read;
            if (frame_ok) o_addr = rx_shift[RW_BIT-1 -: ADDR_W];
            if (o_wr_en)  o_wdata = rx_shift[DATA_W-1:0];
        end
    end

    assign o_busy = ~ss_n_s;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            o_spi_miso <= 1'b0;
            rd_buf     <= '0;
            rd_capture <= 1'b0;
            ss_pend    <= 1'b0;
        end else begin
            rd_capture <= (state == COMMIT) && is_read && !rd_capture;
            if (rd_capture) rd_buf <= i_rdata;

            if (start)                          ss_pend <= 1'b0;
            else if (state == COMMIT && ss_fall) ss_pend <= 1'b1;

            if (state != SHIFT) o_spi_miso <= 1'b0;

            if (start) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                // Read data captured this very cycle must already be in the new frame.
                tx_shift <= {{(FRAME_W-DATA_W){1'b0}}, (rd_capture ? i_rdata : rd_buf)};
            end else if (state == SHIFT) begin
                if (sck_rise) begin
                    rx_shift <= {rx_shift[FRAME_W-2:0], mosi_s};
                    if (bit_cnt != CNT_W'(FRAME_W + 1)) bit_cnt <= bit_cnt + 1'b1;
                end else if (sck_fall) begin
                    o_spi_miso <= tx_shift[FRAME_W-1];
                    tx_shift   <= tx_shift << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_spi_slave.sv
// Directed bench for sha256_spi_slave: 20 MHz i_clk, 2 MHz mode-3 SPI master
// model, a registered register-bank read model and a strobe monitor.
module tb_sha256_spi_slave;

    localparam time CLK_HALF = 25ns;
    localparam time SCK_HALF = 250ns;
    localparam time GAP      = 1000ns;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b1;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       wr_en, rd_en, frame_err, busy;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata = 8'h00;

    int checks = 0;
    int failures = 0;

    int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
    logic [6:0]  rd_addr_last = '0;
    logic [14:0] wr_log[$];

    sha256_spi_slave dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sck(sck), .i_ss_n(ss_n),
        .i_spi_mosi(mosi), .o_spi_miso(miso), .o_wr_en(wr_en), .o_rd_en(rd_en),
        .o_addr(addr), .o_wdata(wdata), .i_rdata(rdata),
        .o_frame_err(frame_err), .o_busy(busy)
    );

    always #(CLK_HALF) clk = ~clk;

    // Register bank: read data appears one cycle after the read strobe.
    always @(posedge clk)
        if (rd_en) rdata <= (addr == 7'd70) ? 8'hBA : 8'h5A;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt <= wr_cnt + 1;
            wr_log.push_back({addr, wdata});
        end
        if (rd_en) begin
            rd_cnt       <= rd_cnt + 1;
            rd_addr_last <= addr;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic send_frame(input logic [16:0] word, input int nbits, output logic [16:0] mbits);
        mbits = '0;
        ss_n = 1'b0;
        #(SCK_HALF);
        for (int i = nbits - 1; i >= 0; i--) begin
            sck  = 1'b0;
            mosi = word[i];
            #(SCK_HALF);
            sck   = 1'b1;
            mbits = {mbits[15:0], miso};
            #(SCK_HALF);
        end
        ss_n = 1'b1;
        #(GAP);
    endtask

    task automatic check_counts(input string name, input int w0, input int r0, input int e0,
                                input int dw, input int dr, input int de);
        checks++;
        if ((wr_cnt - w0) !== dw || (rd_cnt - r0) !== dr || (err_cnt - e0) !== de) begin
            failures++;
            $display("FAIL %s: wr/rd/err got %0d/%0d/%0d expected %0d/%0d/%0d", name,
                     wr_cnt - w0, rd_cnt - r0, err_cnt - e0, dw, dr, de);
        end
    endtask

    task automatic test_reset;
        int w0, r0, e0;
        rst_n = 1'b0;
        #(200ns);
        checks++;
        if ({wr_en, rd_en, frame_err, busy, miso, addr, wdata} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %05h expected 00000",
                     {wr_en, rd_en, frame_err, busy, miso, addr, wdata});
        end
        rst_n = 1'b1;
        #(200ns);
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        ss_n = 1'b0;
        #(300ns);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_high: got %b expected 1", busy);
        end
        ss_n = 1'b1;
        #(300ns);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_low: got %b expected 0", busy);
        end
        #(GAP);
        check_counts("empty_frame", w0, r0, e0, 0, 0, 1);
    endtask

    task automatic test_write;
        int w0, r0, e0;
        logic [16:0] mb;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        send_frame(17'h085A5, 16, mb);
        check_counts("write_85A5", w0, r0, e0, 1, 0, 0);
        checks++;
        if (wr_log[wr_log.size() - 1] !== {7'd5, 8'hA5}) begin
            failures++;
            $display("FAIL write_addr_data: got %04h expected %04h", wr_log[wr_log.size() - 1], {7'd5, 8'hA5});
        end
        checks++;
        if (mb[15:0] !== 16'h0000) begin
            failures++;
            $display("FAIL write_miso: got %04h expected 0000", mb[15:0]);
        end
    endtask

    task automatic test_read;
        int w0, r0, e0;
        logic [16:0] mb;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        send_frame(17'h04600, 16, mb);
        check_counts("read_4600", w0, r0, e0, 0, 1, 0);
        checks++;
        if (rd_addr_last !== 7'd70) begin
            failures++;
            $display("FAIL read_addr: got %0d expected 70", rd_addr_last);
        end
        send_frame(17'h08A11, 16, mb);
        checks++;
        if (mb[15:0] !== 16'h00BA) begin
            failures++;
            $display("FAIL read_return: got %04h expected 00BA", mb[15:0]);
        end
        check_counts("read_followup", w0, r0, e0, 1, 1, 0);
    endtask

    task automatic test_truncated;
        int w0, r0, e0;
        logic [16:0] mb;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        send_frame(17'h00155, 9, mb);
        check_counts("short_frame", w0, r0, e0, 0, 0, 1);
        send_frame(17'h08101, 16, mb);
        check_counts("after_short", w0, r0, e0, 1, 0, 1);
        checks++;
        if (wr_log[wr_log.size() - 1] !== {7'd1, 8'h01}) begin
            failures++;
            $display("FAIL after_short_data: got %04h expected %04h", wr_log[wr_log.size() - 1], {7'd1, 8'h01});
        end
    endtask

    task automatic test_long;
        int w0, r0, e0;
        logic [16:0] mb;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        send_frame({16'h8123, 1'b1}, 17, mb);
        check_counts("long_frame", w0, r0, e0, 0, 0, 1);
        checks++;
        if (mb !== {16'h00BA, 1'b0}) begin
            failures++;
            $display("FAIL long_miso: got %05h expected %05h", mb, {16'h00BA, 1'b0});
        end
        send_frame(17'h08000, 16, mb);
        checks++;
        if (mb[15:0] !== 16'h00BA) begin
            failures++;
            $display("FAIL rd_buf_kept: got %04h expected 00BA", mb[15:0]);
        end
    endtask

    task automatic test_back_to_back;
        int w0, r0, e0, base;
        logic [16:0] mb;
        logic [7:0]  k8;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        base = wr_log.size();
        for (int k = 0; k < 64; k++) begin
            k8 = 8'(k);
            send_frame({1'b0, 1'b1, k8[6:0], k8 ^ 8'h3C}, 16, mb);
        end
        check_counts("b2b_counts", w0, r0, e0, 64, 0, 0);
        for (int k = 0; k < 64; k++) begin
            k8 = 8'(k);
            checks++;
            if (base + k >= wr_log.size()) begin
                failures++;
                $display("FAIL b2b_entry_%0d: got none expected %04h", k, {k8[6:0], k8 ^ 8'h3C});
            end else if (wr_log[base + k] !== {k8[6:0], k8 ^ 8'h3C}) begin
                failures++;
                $display("FAIL b2b_entry_%0d: got %04h expected %04h", k, wr_log[base + k], {k8[6:0], k8 ^ 8'h3C});
            end
        end
    endtask

    task automatic test_reset_midframe;
        int w0, r0, e0;
        logic [16:0] mb;
        logic [15:0] word;
        word = 16'h8F77;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        ss_n = 1'b0;
        #(SCK_HALF);
        for (int i = 15; i >= 0; i--) begin
            sck  = 1'b0;
            mosi = word[i];
            #(SCK_HALF);
            sck = 1'b1;
            #(SCK_HALF);
            if (i == 8) begin
                rst_n = 1'b0;
                #(1ns);
                checks++;
                if ({wr_en, rd_en, frame_err, busy, miso, addr, wdata} !== 20'h0) begin
                    failures++;
                    $display("FAIL midframe_reset_outputs: got %05h expected 00000",
                             {wr_en, rd_en, frame_err, busy, miso, addr, wdata});
                end
            end
        end
        ss_n = 1'b1;
        #(GAP);
        rst_n = 1'b1;
        #(GAP);
        check_counts("reset_frame_dropped", w0, r0, e0, 0, 0, 0);
        send_frame(17'h08E42, 16, mb);
        check_counts("after_reset", w0, r0, e0, 1, 0, 0);
        checks++;
        if (wr_log[wr_log.size() - 1] !== {7'h0E, 8'h42} || mb[15:0] !== 16'h0000) begin
            failures++;
            $display("FAIL after_reset_data: got %04h/%04h expected %04h/0000",
                     wr_log[wr_log.size() - 1], mb[15:0], {7'h0E, 8'h42});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_truncated();
        test_long();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
